// File: rtl/uart_rx_byte_fifo.sv
// uart_rx_byte_fifo
//   Buffers received UART bytes and hands them to the mode FSM as one-cycle
//   rx_data/rx_done strobes, only when the consumer is ready to sample.
//   Optional write-side line-ending normalisation: CR -> space (confirm key),
//   LF dropped.
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   byte_in/byte_valid  byte strobe from the UART receiver
//   clear_rx_buffer     one-cycle flush from the mode FSM (highest priority)
//   consumer_ready      consumer can sample this cycle
//   rx_data/rx_done     delivered byte and its one-cycle strobe
//   fifo_count          entries stored; fifo_empty when zero
//   overflow            sticky: a byte was dropped on a full FIFO
module uart_rx_byte_fifo #(
  parameter int DEPTH      = 16,
  parameter int GAP_CYCLES = 1,
  parameter bit MAP_CR     = 1'b1,
  parameter bit DROP_LF    = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [7:0]                 byte_in,
  input  logic                       byte_valid,
  input  logic                       clear_rx_buffer,
  input  logic                       consumer_ready,
  output logic [7:0]                 rx_data,
  output logic                       rx_done,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count,
  output logic                       fifo_empty,
  output logic                       overflow
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);
  // Last gap-counter value before returning to IDLE; unused when GAP_CYCLES=0
  localparam logic [3:0] GAP_LAST = (GAP_CYCLES == 0) ? 4'd0 : 4'(GAP_CYCLES - 1);

  typedef enum logic [0:0] {IDLE, GAP} state_t;

  state_t        state;
  logic [3:0]    gap_cnt;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [7:0]    mem [DEPTH];

  logic       wr_en, wr_ok, pop, full;
  logic [7:0] wr_byte;

  assign fifo_empty = (fifo_count == '0);
  assign full       = (fifo_count == CW'(DEPTH));

  // LF filtered out before it counts as a write, so it can never overflow
  assign wr_en   = byte_valid && !(DROP_LF && byte_in == 8'h0A);
  assign wr_byte = (MAP_CR && byte_in == 8'h0D) ? 8'h20 : byte_in;

  // !rx_done keeps strobes non-adjacent even with GAP_CYCLES=0
  assign pop   = (state == IDLE) && !fifo_empty && consumer_ready && !rx_done;
  // A full FIFO still accepts a write when a pop frees a slot in the same cycle
  assign wr_ok = wr_en && (!full || pop);

  // Storage carries no reset; validity is tracked by pointers and count
  always_ff @(posedge clk) begin
    if (wr_ok && !clear_rx_buffer) mem[wr_ptr] <= wr_byte;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      gap_cnt    <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
      rx_data    <= 8'h00;
      rx_done    <= 1'b0;
    end else if (clear_rx_buffer) begin
      // Flush: drops the coincident byte and cancels any pending emission
      state      <= IDLE;
      gap_cnt    <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
      rx_done    <= 1'b0;
    end else begin
      rx_done <= 1'b0;
      if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
      if (wr_en && !wr_ok) overflow <= 1'b1;
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_ok, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
      unique case (state)
        IDLE: begin
          if (pop) begin
            rx_data <= mem[rd_ptr];
            rx_done <= 1'b1;
            gap_cnt <= '0;
            state   <= (GAP_CYCLES == 0) ? IDLE : GAP;
          end
        end
        GAP: begin
          if (gap_cnt == GAP_LAST) begin
            gap_cnt <= '0;
            state   <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_byte_fifo.sv
module tb_uart_rx_byte_fifo;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] byte_in = 8'h00;
  logic       byte_valid = 1'b0;
  logic       clear_rx_buffer = 1'b0;
  logic       consumer_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_done;
  logic [4:0] fifo_count;
  logic       fifo_empty;
  logic       overflow;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [7:0] rx_q[$];
  int         rx_cyc_q[$];
  logic [7:0] exp_q[$];
  bit         prev_done = 1'b0;

  uart_rx_byte_fifo #(.DEPTH(16), .GAP_CYCLES(1), .MAP_CR(1'b1), .DROP_LF(1'b1)) dut (
    .clk(clk), .rst(rst), .byte_in(byte_in), .byte_valid(byte_valid),
    .clear_rx_buffer(clear_rx_buffer), .consumer_ready(consumer_ready),
    .rx_data(rx_data), .rx_done(rx_done), .fifo_count(fifo_count),
    .fifo_empty(fifo_empty), .overflow(overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Collect every delivered byte; strobes must never touch
  always @(negedge clk) begin
    if (rx_done) begin
      rx_q.push_back(rx_data);
      rx_cyc_q.push_back(cyc);
      checks++;
      if (prev_done) begin
        failures++;
        $display("FAIL rx_done_adjacent at cycle %0d", cyc);
      end
    end
    prev_done = rx_done;
  end

  initial begin
    #300000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Reference: a terminal byte stream after line-ending normalisation
  function automatic void mdl_push(input logic [7:0] b);
    if (b == 8'h0A) return;
    exp_q.push_back((b == 8'h0D) ? 8'h20 : b);
  endfunction

  function automatic logic [7:0] rand_plain();
    logic [7:0] b;
    b = 8'($urandom);
    if (b == 8'h0A || b == 8'h0D) b = 8'h41;
    return b;
  endfunction

  task automatic push_byte(input logic [7:0] b);
    byte_valid = 1'b1; byte_in = b;
    step();
    byte_valid = 1'b0;
  endtask

  task automatic wait_rx(input int n, input int budget, input string name);
    for (int k = 0; k < budget && rx_q.size() < n; k++) step();
    repeat (4) step();
    checks++;
    if (rx_q.size() != n) begin
      failures++;
      $display("FAIL %s_count got=%0d exp=%0d", name, rx_q.size(), n);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (rx_data !== 8'h00 || rx_done !== 1'b0 || fifo_count !== 5'd0 ||
        fifo_empty !== 1'b1 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL reset_state got data=%h done=%b cnt=%0d empty=%b ovf=%b", rx_data, rx_done, fifo_count, fifo_empty, overflow);
    end
    step();
    rst = 1'b0;
  endtask

  task automatic test_latency();
    int n;
    consumer_ready = 1'b1;
    while (cyc < 10) step();
    n = cyc;
    byte_valid = 1'b1; byte_in = 8'h35;
    step();
    byte_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (fifo_count !== 5'd1 || rx_done !== 1'b0) begin
      failures++;
      $display("FAIL latency_n1 got cnt=%0d done=%b exp cnt=1 done=0", fifo_count, rx_done);
    end
    step();
    @(negedge clk);
    checks++;
    if (cyc != n + 2 || rx_done !== 1'b1 || rx_data !== 8'h35 || fifo_count !== 5'd0) begin
      failures++;
      $display("FAIL latency_n2 got done=%b data=%h cnt=%0d exp 1/35/0", rx_done, rx_data, fifo_count);
    end
    step();
    @(negedge clk);
    checks++;
    if (rx_done !== 1'b0) begin
      failures++;
      $display("FAIL latency_n3 got done=%b exp 0", rx_done);
    end
    repeat (3) step();
  endtask

  task automatic test_burst();
    int n;
    logic [7:0] seq [4];
    seq[0] = 8'h31; seq[1] = 8'h32; seq[2] = 8'h0D; seq[3] = 8'h0A;
    rx_q.delete(); rx_cyc_q.delete(); exp_q.delete();
    consumer_ready = 1'b1;
    n = cyc;
    for (int i = 0; i < 4; i++) begin
      mdl_push(seq[i]);
      byte_valid = 1'b1; byte_in = seq[i];
      step();
    end
    byte_valid = 1'b0;
    repeat (10) step();
    checks++;
    if (rx_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL burst_count got=%0d exp=%0d", rx_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (rx_q[i] !== exp_q[i] || rx_cyc_q[i] != n + 2 + 2 * i) begin
          failures++;
          $display("FAIL burst_item%0d got=%h@%0d exp=%h@%0d", i, rx_q[i], rx_cyc_q[i], exp_q[i], n + 2 + 2 * i);
        end
      end
    end
    @(negedge clk);
    checks++;
    if (rx_data !== 8'h20) begin
      failures++;
      $display("FAIL burst_hold got=%h exp=20", rx_data);
    end
    step();
  endtask

  task automatic test_backpressure();
    logic [7:0] b;
    rx_q.delete(); exp_q.delete();
    consumer_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      b = rand_plain();
      mdl_push(b);
      push_byte(b);
    end
    step();
    @(negedge clk);
    checks++;
    if (fifo_count !== 5'd5) begin
      failures++;
      $display("FAIL bp_count got=%0d exp=5", fifo_count);
    end
    step();
    checks++;
    if (rx_q.size() != 0) begin
      failures++;
      $display("FAIL bp_held got=%0d pulses exp=0", rx_q.size());
    end
    consumer_ready = 1'b1;
    wait_rx(5, 100, "bp_drain");
    for (int i = 0; i < 5 && i < rx_q.size(); i++) begin
      checks++;
      if (rx_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL bp_item%0d got=%h exp=%h", i, rx_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_overflow();
    logic [7:0] b;
    rx_q.delete(); exp_q.delete();
    consumer_ready = 1'b0;
    for (int i = 0; i < 17; i++) begin
      b = rand_plain();
      if (exp_q.size() < 16) mdl_push(b);
      push_byte(b);
    end
    @(negedge clk);
    checks++;
    if (fifo_count !== 5'd16 || overflow !== 1'b1 || fifo_empty !== 1'b0) begin
      failures++;
      $display("FAIL ovf_state got cnt=%0d ovf=%b empty=%b exp 16/1/0", fifo_count, overflow, fifo_empty);
    end
    step();
    consumer_ready = 1'b1;
    wait_rx(16, 200, "ovf_drain");
    for (int i = 0; i < 16 && i < rx_q.size(); i++) begin
      checks++;
      if (rx_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL ovf_item%0d got=%h exp=%h", i, rx_q[i], exp_q[i]);
      end
    end
    @(negedge clk);
    checks++;
    if (overflow !== 1'b1) begin
      failures++;
      $display("FAIL ovf_sticky got=%b exp=1", overflow);
    end
    step();
  endtask

  task automatic test_clear();
    rx_q.delete();
    consumer_ready = 1'b0;
    for (int i = 0; i < 3; i++) push_byte(rand_plain());
    byte_valid = 1'b1; byte_in = 8'h39; clear_rx_buffer = 1'b1;
    step();
    byte_valid = 1'b0; clear_rx_buffer = 1'b0;
    @(negedge clk);
    checks++;
    if (fifo_count !== 5'd0 || fifo_empty !== 1'b1 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL clear_state got cnt=%0d empty=%b ovf=%b exp 0/1/0", fifo_count, fifo_empty, overflow);
    end
    step();
    consumer_ready = 1'b1;
    repeat (10) step();
    checks++;
    if (rx_q.size() != 0) begin
      failures++;
      $display("FAIL clear_emitted got=%0d pulses exp=0", rx_q.size());
    end
  endtask

  task automatic test_full_pushpop();
    logic [7:0] b;
    rx_q.delete(); exp_q.delete();
    consumer_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      b = rand_plain();
      mdl_push(b);
      push_byte(b);
    end
    @(negedge clk);
    checks++;
    if (fifo_count !== 5'd16) begin
      failures++;
      $display("FAIL full_fill got=%0d exp=16", fifo_count);
    end
    step();
    b = rand_plain();
    mdl_push(b);
    consumer_ready = 1'b1;
    push_byte(b);
    @(negedge clk);
    checks++;
    if (fifo_count !== 5'd16 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL full_pushpop got cnt=%0d ovf=%b exp 16/0", fifo_count, overflow);
    end
    wait_rx(17, 200, "full_drain");
    for (int i = 0; i < 17 && i < rx_q.size(); i++) begin
      checks++;
      if (rx_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL full_item%0d got=%h exp=%h", i, rx_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] b;
    int n;
    for (int r = 0; r < 6; r++) begin
      rx_q.delete(); exp_q.delete();
      n = $urandom_range(1, 12);
      for (int i = 0; i < n; i++) begin
        case ($urandom_range(0, 7))
          0:       b = 8'h0A;
          1:       b = 8'h0D;
          default: b = 8'($urandom);
        endcase
        mdl_push(b);
        consumer_ready = 1'($urandom);
        push_byte(b);
        repeat ($urandom_range(0, 2)) begin
          consumer_ready = 1'($urandom);
          step();
        end
      end
      consumer_ready = 1'b1;
      wait_rx(exp_q.size(), 200, "rand_drain");
      for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
        checks++;
        if (rx_q[i] !== exp_q[i]) begin
          failures++;
          $display("FAIL rand_r%0d_item%0d got=%h exp=%h", r, i, rx_q[i], exp_q[i]);
        end
      end
      @(negedge clk);
      checks++;
      if (overflow !== 1'b0 || fifo_empty !== 1'b1) begin
        failures++;
        $display("FAIL rand_r%0d_end got ovf=%b empty=%b exp 0/1", r, overflow, fifo_empty);
      end
      step();
    end
  endtask

  task automatic test_async_reset();
    rx_q.delete();
    consumer_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_byte(rand_plain());
    #2 rst = 1'b1;
    #1;
    checks++;
    if (fifo_count !== 5'd0 || fifo_empty !== 1'b1 || rx_done !== 1'b0 || rx_data !== 8'h00) begin
      failures++;
      $display("FAIL async_reset got cnt=%0d empty=%b done=%b data=%h exp 0/1/0/00", fifo_count, fifo_empty, rx_done, rx_data);
    end
    step();
    rst = 1'b0;
    consumer_ready = 1'b1;
    repeat (6) step();
    checks++;
    if (rx_q.size() != 0) begin
      failures++;
      $display("FAIL async_reset_emit got=%0d pulses exp=0", rx_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_burst();
    test_backpressure();
    test_overflow();
    test_clear();
    test_full_pushpop();
    test_random();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
